// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard scoreboard: stalls, forwarding selects, branch flush
// Three in-flight write slots mirror ID/EX, EX/MEM and MEM/WB.
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_SRC      = 2,
    parameter int ALLOW_FWD    = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dst_addr,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          branch_taken,
    output logic                          stall,
    output logic                          flush,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic [(1<<REG_ADDR_W)-1:0]    pending,
    output logic [CNT_W-1:0]              stall_count,
    output logic [CNT_W-1:0]              flush_count
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    logic                  eValid, mValid, wValid;
    logic [REG_ADDR_W-1:0] eDst, mDst, wDst;
    logic                  eLoad;
    logic [FC_W-1:0]       flushCnt;

    logic [NUM_SRC-1:0]    matchE, matchM;
    logic [NUM_SRC*2-1:0]  fwdNext;
    logic                  loadUse, interlock, advance;
    logic [REG_ADDR_W-1:0] srcAddr;
    logic                  srcHit;

    always_comb begin
        matchE  = '0;
        matchM  = '0;
        srcAddr = '0;
        srcHit  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            srcAddr   = id_src_addr[k*REG_ADDR_W +: REG_ADDR_W];
            // r0 is hard-wired, so it never creates a dependency
            srcHit    = id_valid & id_src_used[k] & (srcAddr != '0);
            matchE[k] = srcHit & eValid & (srcAddr == eDst);
            matchM[k] = srcHit & mValid & (srcAddr == mDst);
        end
    end

    always_comb begin
        flush     = branch_taken | (flushCnt != '0);
        loadUse   = (|matchE) & eLoad;
        interlock = (|matchE) | (|matchM);
        stall     = 1'b0;
        if (!flush) begin
            stall = (ALLOW_FWD != 0) ? loadUse : interlock;
        end
        advance = id_valid & ~stall & ~flush;
    end

    // Youngest producer wins; a WB match is covered by write-before-read in the regfile
    always_comb begin
        fwdNext = '0;
        if (ALLOW_FWD != 0 && advance) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (matchE[k]) begin
                    fwdNext[k*2 +: 2] = 2'b01;
                end else if (matchM[k]) begin
                    fwdNext[k*2 +: 2] = 2'b10;
                end
            end
        end
    end

    always_comb begin
        pending = '0;
        if (eValid) pending[eDst] = 1'b1;
        if (mValid) pending[mDst] = 1'b1;
        if (wValid) pending[wDst] = 1'b1;
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eValid      <= 1'b0;
            mValid      <= 1'b0;
            wValid      <= 1'b0;
            eDst        <= '0;
            mDst        <= '0;
            wDst        <= '0;
            eLoad       <= 1'b0;
            flushCnt    <= '0;
            fwd_sel     <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            wValid  <= mValid;
            wDst    <= mDst;
            mValid  <= eValid;
            mDst    <= eDst;
            // Stalls and flushes leave a bubble in E; the squashed instruction never lands
            eValid  <= advance & id_reg_write & (id_dst_addr != '0);
            eDst    <= id_dst_addr;
            eLoad   <= id_mem_read;
            fwd_sel <= fwdNext;

            if (branch_taken) begin
                flushCnt <= FLUSH_RELOAD;
            end else if (flushCnt != '0) begin
                flushCnt <= flushCnt - FC_W'(1);
            end

            if (stall && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard, forwarding and interlock instances
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        branch_taken;

    logic        stallF, flushF, stallI, flushI;
    logic [3:0]  fwdF, fwdI;
    logic [31:0] pendF, pendI;
    logic [15:0] scF, fcF, scI, fcI;

    always #5 clk = ~clk;

    hazard_scoreboard #(.ALLOW_FWD(1)) dutFwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .branch_taken(branch_taken), .stall(stallF), .flush(flushF),
        .fwd_sel(fwdF), .pending(pendF), .stall_count(scF), .flush_count(fcF)
    );

    hazard_scoreboard #(.ALLOW_FWD(0)) dutIlk (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .branch_taken(branch_taken), .stall(stallI), .flush(flushI),
        .fwd_sel(fwdI), .pending(pendI), .stall_count(scI), .flush_count(fcI)
    );

    // fields: 0 stall, 1 flush, 2 fwd_sel, 3 pending, 4 stall_count, 5 flush_count
    typedef struct {
        int          cyc;
        int          dut;
        int          fld;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nTests = 0;
    int   nFail = 0;
    int   mi;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int dut, input int fld);
        logic [31:0] r;
        r = '0;
        case (fld)
            0: r = 32'(dut == 0 ? stallF : stallI);
            1: r = 32'(dut == 0 ? flushF : flushI);
            2: r = 32'(dut == 0 ? fwdF : fwdI);
            3: r = (dut == 0) ? pendF : pendI;
            4: r = 32'(dut == 0 ? scF : scI);
            5: r = 32'(dut == 0 ? fcF : fcI);
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        mi = 0;
        while (mi < q.size()) begin
            if (q[mi].cyc == cyc) begin
                nTests++;
                if (actual(q[mi].dut, q[mi].fld) !== q[mi].val) begin
                    nFail++;
                    $display("FAIL %s (dut%0d cyc %0d): got %0h expected %0h", q[mi].nm,
                             q[mi].dut, cyc, actual(q[mi].dut, q[mi].fld), q[mi].val);
                end
                q.delete(mi);
            end else if (q[mi].cyc < cyc) begin
                nTests++;
                nFail++;
                $display("FAIL %s: check for cycle %0d never sampled", q[mi].nm, q[mi].cyc);
                q.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst, input logic rw,
                         input logic ml, input logic br);
        id_valid     = v;
        id_src_addr  = {s1, s0};
        id_src_used  = used;
        id_dst_addr  = dst;
        id_reg_write = rw;
        id_mem_read  = ml;
        branch_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input int off, input int dut, input int fld, input logic [31:0] v,
                       input string nm);
        exp_t e;
        e.cyc = cyc + off;
        e.dut = dut;
        e.fld = fld;
        e.val = v;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic chkAllZero(input string nm);
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < 6; f++) begin
                chk(0, d, f, 32'h0, nm);
            end
        end
    endtask

    task automatic pulseReset();
        step();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        idle();
        step();
        chkAllZero("resetState");
        rst = 1'b1;

        // ALU forwarding: I1 writes r3, I2 reads r3 (src0), I3 reads r3 (src1)
        step(); drive(1, 0, 0, 2'b00, 3, 1, 0, 0);
        chk(0, 0, 0, 0, "aluStallI1"); chk(0, 0, 3, 32'h0, "aluPendI1");
        step(); drive(1, 3, 0, 2'b01, 7, 1, 0, 0);
        chk(0, 0, 0, 0, "aluStallI2"); chk(0, 0, 3, 32'h8, "aluPendI2");
        chk(1, 0, 2, 32'h1, "aluFwdI2");
        step(); drive(1, 0, 3, 2'b10, 0, 0, 0, 0);
        chk(0, 0, 0, 0, "aluStallI3"); chk(0, 0, 3, 32'h88, "aluPendI3");
        chk(1, 0, 2, 32'h8, "aluFwdI3");
        step(); idle();
        chk(0, 0, 3, 32'h88, "aluPendDrain");
        pulseReset();

        // Load-use: load r5, then add r6 <- r5
        step(); drive(1, 0, 0, 2'b00, 5, 1, 1, 0);
        chk(0, 0, 0, 0, "luStallLoad");
        step(); drive(1, 5, 0, 2'b01, 6, 1, 0, 0);
        chk(0, 0, 0, 1, "luStall1"); chk(0, 0, 3, 32'h20, "luPend1"); chk(0, 0, 4, 0, "luCnt0");
        step();
        chk(0, 0, 0, 0, "luStall2"); chk(0, 0, 4, 1, "luCnt1"); chk(1, 0, 2, 32'h2, "luFwd");
        step(); idle();
        chk(0, 0, 4, 1, "luCntFinal"); chk(0, 0, 3, 32'h60, "luPendDrain");
        pulseReset();

        // r0 destination never tracked
        step(); drive(1, 0, 0, 2'b00, 0, 1, 0, 0);
        chk(0, 0, 3, 0, "r0PendW");
        step(); drive(1, 0, 0, 2'b01, 0, 0, 0, 0);
        chk(0, 0, 0, 0, "r0StallFwd"); chk(0, 1, 0, 0, "r0StallIlk");
        chk(0, 0, 3, 0, "r0PendFwd"); chk(0, 1, 3, 0, "r0PendIlk");
        chk(1, 0, 2, 0, "r0Fwd");
        step(); idle();
        pulseReset();

        // Branch coincident with a load-use match
        step(); drive(1, 0, 0, 2'b00, 5, 1, 1, 0);
        step(); drive(1, 5, 0, 2'b01, 6, 1, 0, 1);
        chk(0, 0, 1, 1, "brFlush1"); chk(0, 0, 0, 0, "brStallMasked");
        chk(0, 0, 3, 32'h20, "brPend1"); chk(0, 0, 5, 0, "brFcnt0");
        step(); drive(1, 5, 0, 2'b01, 6, 1, 0, 0);
        chk(0, 0, 1, 1, "brFlush2"); chk(0, 0, 3, 32'h20, "brPend2"); chk(0, 0, 5, 1, "brFcnt1");
        step(); idle();
        chk(0, 0, 1, 0, "brFlushEnd"); chk(0, 0, 5, 2, "brFcnt2");
        chk(0, 0, 4, 0, "brScntZero"); chk(0, 0, 3, 32'h20, "brPendSquash");
        pulseReset();

        // Interlock: ALU producer then dependent consumer
        step(); drive(1, 0, 0, 2'b00, 3, 1, 0, 0);
        step(); drive(1, 3, 0, 2'b01, 8, 1, 0, 0);
        chk(0, 1, 0, 1, "ilkStall1"); chk(0, 1, 4, 0, "ilkCnt0");
        step();
        chk(0, 1, 0, 1, "ilkStall2"); chk(0, 1, 4, 1, "ilkCnt1");
        step();
        chk(0, 1, 0, 0, "ilkRelease"); chk(0, 1, 4, 2, "ilkCnt2"); chk(1, 1, 2, 0, "ilkFwd");
        step(); idle();
        chk(0, 1, 4, 2, "ilkCntFinal");
        pulseReset();

        // Asynchronous reset while a flush is active and counters are nonzero
        step(); drive(1, 0, 0, 2'b00, 3, 1, 0, 0);
        step(); drive(1, 3, 0, 2'b01, 8, 1, 0, 0);
        chk(0, 1, 0, 1, "rstPreStall");
        step(); drive(1, 3, 0, 2'b01, 8, 1, 0, 1);
        chk(0, 0, 1, 1, "rstPreFlushF"); chk(0, 1, 1, 1, "rstPreFlushI"); chk(0, 1, 0, 0, "rstPreStallMask");
        step(); idle();
        #2 rst = 1'b0;
        chkAllZero("rstAsync");
        step(); rst = 1'b1;
        chk(0, 0, 3, 0, "rstPendF"); chk(0, 1, 3, 0, "rstPendI");
        chk(0, 1, 4, 0, "rstScnt"); chk(0, 0, 5, 0, "rstFcnt");
        step();
        step();

        while (q.size() > 0) begin
            nTests++;
            nFail++;
            $display("FAIL %s: expectation left unchecked", q[0].nm);
            void'(q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
